// File: rtl/id_ex_skid_pkg.sv
// rtl/id_ex_skid_pkg.sv - shared types and constants for the id/ex skid buffer
package id_ex_skid_pkg;

    localparam int          ID_EX_PAYLOAD_W = 327;
    localparam logic [31:0] ID_EX_NOP_INST  = 32'h00000013;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] inst_addr;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] op1_jump;
        logic [31:0] op2_jump;
        logic [31:0] reg1_rdata;
        logic [31:0] reg2_rdata;
        logic [31:0] csr_rdata;
        logic [31:0] csr_waddr;
        logic        reg_we;
        logic [4:0]  reg_waddr;
        logic        csr_we;
    } id_ex_payload_t;

    // Side-effect-free payload shown to ex whenever no entry is valid.
    function automatic id_ex_payload_t bubble_payload(input logic [31:0] nop_inst);
        id_ex_payload_t b;
        b      = '0;
        b.inst = nop_inst;
        return b;
    endfunction

endpackage

// File: rtl/id_ex_entry.sv
// rtl/id_ex_entry.sv - one packed payload register with load enable and async clear
module id_ex_entry
    import id_ex_skid_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load,
    input  logic [ID_EX_PAYLOAD_W-1:0] d,
    output logic [ID_EX_PAYLOAD_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/id_ex_skid.sv
// rtl/id_ex_skid.sv - id/ex two-entry skid buffer; perf counters under ID_EX_PERF_CNT_EN
module id_ex_skid
    import id_ex_skid_pkg::*;
#(
    parameter logic [31:0] NOP_INST = ID_EX_NOP_INST,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      inst_i,
    input  logic [31:0]      inst_addr_i,
    input  logic [31:0]      op1_i,
    input  logic [31:0]      op2_i,
    input  logic [31:0]      op1_jump_i,
    input  logic [31:0]      op2_jump_i,
    input  logic [31:0]      reg1_rdata_i,
    input  logic [31:0]      reg2_rdata_i,
    input  logic [31:0]      csr_rdata_i,
    input  logic [31:0]      csr_waddr_i,
    input  logic             reg_we_i,
    input  logic [4:0]       reg_waddr_i,
    input  logic             csr_we_i,
    input  logic             jump_flag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      inst_o,
    output logic [31:0]      inst_addr_o,
    output logic [31:0]      op1_o,
    output logic [31:0]      op2_o,
    output logic [31:0]      op1_jump_o,
    output logic [31:0]      op2_jump_o,
    output logic [31:0]      reg1_rdata_o,
    output logic [31:0]      reg2_rdata_o,
    output logic [31:0]      csr_rdata_o,
    output logic [31:0]      csr_waddr_o,
    output logic             reg_we_o,
    output logic [4:0]       reg_waddr_o,
    output logic             csr_we_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    skid_state_e    state, state_nxt;
    id_ex_payload_t in_pl, main_d, main_q, skid_q, out_pl;
    logic           accept, issue, main_load, skid_load;

    assign in_pl = '{inst: inst_i, inst_addr: inst_addr_i, op1: op1_i, op2: op2_i,
                     op1_jump: op1_jump_i, op2_jump: op2_jump_i,
                     reg1_rdata: reg1_rdata_i, reg2_rdata: reg2_rdata_i,
                     csr_rdata: csr_rdata_i, csr_waddr: csr_waddr_i,
                     reg_we: reg_we_i, reg_waddr: reg_waddr_i, csr_we: csr_we_i};

    assign out_valid_o = (state != ST_EMPTY);
    assign accept      = in_valid_i & in_ready_o;
    assign issue       = out_valid_o & out_ready_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_EMPTY;
            in_ready_o <= 1'b1;
        end else begin
            state      <= state_nxt;
            in_ready_o <= (state_nxt != ST_TWO);
        end
    end

    always_comb begin
        state_nxt = state;
        main_load = 1'b0;
        skid_load = 1'b0;
        if (jump_flag_i) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_nxt = ST_ONE;
                        main_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && issue) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        state_nxt = ST_TWO;
                        skid_load = 1'b1;
                    end else if (issue) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // The skid holds the younger instruction; it moves up once main issues.
                    if (issue) begin
                        state_nxt = ST_ONE;
                        main_load = 1'b1;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    assign main_d = (state == ST_TWO) ? skid_q : in_pl;

    id_ex_entry u_main (
        .clk   (clk),
        .rst_n (rst),
        .load  (main_load),
        .d     (main_d),
        .q     (main_q)
    );

    id_ex_entry u_skid (
        .clk   (clk),
        .rst_n (rst),
        .load  (skid_load),
        .d     (in_pl),
        .q     (skid_q)
    );

    assign out_pl       = out_valid_o ? main_q : bubble_payload(NOP_INST);
    assign inst_o       = out_pl.inst;
    assign inst_addr_o  = out_pl.inst_addr;
    assign op1_o        = out_pl.op1;
    assign op2_o        = out_pl.op2;
    assign op1_jump_o   = out_pl.op1_jump;
    assign op2_jump_o   = out_pl.op2_jump;
    assign reg1_rdata_o = out_pl.reg1_rdata;
    assign reg2_rdata_o = out_pl.reg2_rdata;
    assign csr_rdata_o  = out_pl.csr_rdata;
    assign csr_waddr_o  = out_pl.csr_waddr;
    assign reg_we_o     = out_pl.reg_we;
    assign reg_waddr_o  = out_pl.reg_waddr;
    assign csr_we_o     = out_pl.csr_we;

`ifdef ID_EX_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid_o && !out_ready_i && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (jump_flag_i && (state != ST_EMPTY) && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt;
    assign flush_cnt_o = flush_cnt;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_id_ex_skid.sv
// tb/tb_id_ex_skid.sv - self-checking bench for id_ex_skid against a queue model
module tb_id_ex_skid;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid_i = 1'b0, in_ready_o;
    logic [31:0] inst_i = '0, inst_addr_i = '0, op1_i = '0, op2_i = '0, op1_jump_i = '0;
    logic [31:0] op2_jump_i = '0, reg1_rdata_i = '0, reg2_rdata_i = '0, csr_rdata_i = '0, csr_waddr_i = '0;
    logic        reg_we_i = 1'b0, csr_we_i = 1'b0, jump_flag_i = 1'b0;
    logic [4:0]  reg_waddr_i = '0;
    logic        out_valid_o, out_ready_i = 1'b0;
    logic [31:0] inst_o, inst_addr_o, op1_o, op2_o, op1_jump_o, op2_jump_o;
    logic [31:0] reg1_rdata_o, reg2_rdata_o, csr_rdata_o, csr_waddr_o;
    logic        reg_we_o, csr_we_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] stall_cnt_o, flush_cnt_o;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [326:0] mq[$];
    logic         m_ready;
    logic [31:0]  m_stall, m_flush;

    id_ex_skid dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .inst_i(inst_i), .inst_addr_i(inst_addr_i), .op1_i(op1_i), .op2_i(op2_i),
        .op1_jump_i(op1_jump_i), .op2_jump_i(op2_jump_i),
        .reg1_rdata_i(reg1_rdata_i), .reg2_rdata_i(reg2_rdata_i),
        .csr_rdata_i(csr_rdata_i), .csr_waddr_i(csr_waddr_i),
        .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i), .csr_we_i(csr_we_i),
        .jump_flag_i(jump_flag_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .inst_o(inst_o), .inst_addr_o(inst_addr_o), .op1_o(op1_o), .op2_o(op2_o),
        .op1_jump_o(op1_jump_o), .op2_jump_o(op2_jump_o),
        .reg1_rdata_o(reg1_rdata_o), .reg2_rdata_o(reg2_rdata_o),
        .csr_rdata_o(csr_rdata_o), .csr_waddr_o(csr_waddr_o),
        .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .csr_we_o(csr_we_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic logic [326:0] in_vec();
        return {inst_i, inst_addr_i, op1_i, op2_i, op1_jump_i, op2_jump_i, reg1_rdata_i,
                reg2_rdata_i, csr_rdata_i, csr_waddr_i, reg_we_i, reg_waddr_i, csr_we_i};
    endfunction

    function automatic logic [326:0] out_vec();
        return {inst_o, inst_addr_o, op1_o, op2_o, op1_jump_o, op2_jump_o, reg1_rdata_o,
                reg2_rdata_o, csr_rdata_o, csr_waddr_o, reg_we_o, reg_waddr_o, csr_we_o};
    endfunction

    task automatic chk(input string tag, input logic [326:0] obs, input logic [326:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [31:0] addr);
        in_valid_i   = v;
        inst_addr_i  = addr;
        inst_i       = $urandom;
        op1_i        = $urandom;
        op2_i        = $urandom;
        op1_jump_i   = $urandom;
        op2_jump_i   = $urandom;
        reg1_rdata_i = $urandom;
        reg2_rdata_i = $urandom;
        csr_rdata_i  = $urandom;
        csr_waddr_i  = $urandom;
        reg_we_i     = 1'($urandom);
        reg_waddr_i  = 5'($urandom);
        csr_we_i     = 1'($urandom);
    endtask

    task automatic model_reset();
        mq.delete();
        m_ready = 1'b1;
        m_stall = '0;
        m_flush = '0;
    endtask

    task automatic check_all();
        logic [326:0] exp_pl;
        exp_pl = (mq.size() > 0) ? mq[0] : {NOP, 295'd0};
        chk("out_valid", 327'(out_valid_o), 327'(mq.size() > 0));
        chk("in_ready", 327'(in_ready_o), 327'(m_ready));
        chk("payload", out_vec(), exp_pl);
`ifdef ID_EX_PERF_CNT_EN
        chk("stall_cnt", 327'(stall_cnt_o), 327'(m_stall));
        chk("flush_cnt", 327'(flush_cnt_o), 327'(m_flush));
`else
        chk("stall_cnt", 327'(stall_cnt_o), 327'd0);
        chk("flush_cnt", 327'(flush_cnt_o), 327'd0);
`endif
    endtask

    // One clock: model decides from pre-edge inputs, DUT is checked 1 time unit after the edge.
    task automatic cycle();
        logic acc, iss;
        logic [326:0] pl;
        acc = in_valid_i && m_ready;
        iss = (mq.size() > 0) && out_ready_i;
        pl  = in_vec();
        if ((mq.size() > 0) && !out_ready_i && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (jump_flag_i && (mq.size() > 0) && m_flush != 32'hFFFF_FFFF) m_flush++;
        @(posedge clk);
        if (jump_flag_i) begin
            mq.delete();
        end else begin
            if (iss) void'(mq.pop_front());
            if (acc) mq.push_back(pl);
        end
        m_ready = (mq.size() < 2);
        #1;
        check_all();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        #2 rst = 1'b1;

        // Streaming at full rate
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 32'(i * 4));
            cycle();
            chk("stream_addr", 327'(inst_addr_o), 327'(i * 4));
        end
        set_in(1'b0, 32'h0);
        cycle();

        // Fill to TWO under stall, then drain in order
        out_ready_i = 1'b0;
        set_in(1'b1, 32'h10);
        cycle();
        set_in(1'b1, 32'h14);
        cycle();
        chk("two_ready_low", 327'(in_ready_o), 327'd0);
        set_in(1'b1, 32'h18);
        cycle();
        chk("two_hold_head", 327'(inst_addr_o), 327'h10);
        out_ready_i = 1'b1;
        cycle();
        chk("drain_1", 327'(inst_addr_o), 327'h14);
        cycle();
        set_in(1'b0, 32'h0);
        chk("drain_2", 327'(inst_addr_o), 327'h18);
        cycle();

        // Flush while in TWO
        out_ready_i = 1'b0;
        set_in(1'b1, 32'h100);
        cycle();
        set_in(1'b1, 32'h104);
        cycle();
        set_in(1'b0, 32'h0);
        jump_flag_i = 1'b1;
        cycle();
        jump_flag_i = 1'b0;
        chk("flush_inst", 327'(inst_o), 327'(NOP));
        chk("flush_ready", 327'(in_ready_o), 327'd1);

        // Flush coincident with an incoming instruction in EMPTY
        out_ready_i = 1'b1;
        set_in(1'b1, 32'h20);
        jump_flag_i = 1'b1;
        cycle();
        jump_flag_i = 1'b0;
        set_in(1'b0, 32'h0);
        cycle();
        chk("dropped_0x20", 327'(out_valid_o), 327'd0);

        // Async reset mid-cycle while ONE
        out_ready_i = 1'b0;
        set_in(1'b1, 32'h30);
        cycle();
        set_in(1'b0, 32'h0);
        #3 rst = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_reg_we", 327'(reg_we_o), 327'd0);
        #2 rst = 1'b1;

        // Five stall cycles with one valid entry
        set_in(1'b1, 32'h40);
        cycle();
        set_in(1'b0, 32'h0);
        repeat (5) cycle();
`ifdef ID_EX_PERF_CNT_EN
        chk("stall_5", 327'(stall_cnt_o), 327'd5);
`else
        chk("stall_5", 327'(stall_cnt_o), 327'd0);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 3) != 0, $urandom);
            out_ready_i = ($urandom_range(0, 3) != 0);
            jump_flag_i = ($urandom_range(0, 15) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
